// File: rtl/proc_pkg.sv
// Shared processor definitions: register-index and data-word types used by the
// register-address stage, decode and the register file.
package proc_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]     data_word_t;

  localparam reg_idx_t ZERO_REG = 3'd0;

  function automatic logic is_zero_reg(input reg_idx_t idx);
    return idx == ZERO_REG;
  endfunction

endpackage

// File: rtl/scoreboard_bits.sv
// Pending-write scoreboard: one bit per architectural register, cleared by
// writeback and set by issue. Bit 0 is never stored and always reads as 0.
module scoreboard_bits
  import proc_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_issue_en,
  input  logic [ADDR_W-1:0]      i_issue_adrs,
  input  logic                   i_wr_en,
  input  logic [ADDR_W-1:0]      i_wr_adrs,
  output logic                   o_issue_stall,
  output logic [(1<<ADDR_W)-1:0] o_pending_vec
);

  localparam int NUM = 1 << ADDR_W;

  logic [NUM-1:1] r_pending;
  logic [NUM-1:1] w_pending_next;
  logic           w_wr_hits_issue;

  assign o_pending_vec   = {r_pending, 1'b0};
  assign w_wr_hits_issue = i_wr_en && (i_wr_adrs == i_issue_adrs);

  // A writeback landing on the same register this cycle frees it for the new owner.
  assign o_issue_stall = i_issue_en && o_pending_vec[i_issue_adrs] && !w_wr_hits_issue;

  // Clear first, then set, so a same-cycle issue keeps the bit owned.
  always_comb begin
    // NOTE: defaulting every always_comb output up front is what keeps this a
    // pure mux; a path that leaves it unassigned would infer a latch.
    w_pending_next = r_pending;
    for (int i = 1; i < NUM; i++) begin
      if (i_wr_en && (i_wr_adrs == ADDR_W'(i))) begin
        w_pending_next[i] = 1'b0;
      end
      if (i_issue_en && !o_issue_stall && (i_issue_adrs == ADDR_W'(i))) begin
        w_pending_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (i_reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

endmodule

// File: rtl/reg_file_scoreboard.sv
// 8x16 register file (r0 hardwired to zero) with a pending-write scoreboard.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module reg_file_scoreboard #(
  parameter int                DATA_W    = proc_pkg::DATA_W,
  parameter int                ADDR_W    = proc_pkg::REG_ADDR_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      rdAdrsA,
  input  logic [ADDR_W-1:0]      rdAdrsB,
  output logic [DATA_W-1:0]      rdDataA,
  output logic [DATA_W-1:0]      rdDataB,
  output logic                   rdBusyA,
  output logic                   rdBusyB,
  input  logic                   issueEn,
  input  logic [ADDR_W-1:0]      issueAdrs,
  input  logic                   wrEn,
  input  logic [ADDR_W-1:0]      wrAdrs,
  input  logic [DATA_W-1:0]      wrData,
  output logic                   issueStall,
  output logic [(1<<ADDR_W)-1:0] pendingVec
);

  localparam int                NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADR = ADDR_W'(proc_pkg::ZERO_REG);

  logic [DATA_W-1:0] r_regs [1:NUM_REGS-1];
  logic              w_wr_live;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic              w_byp_a;
  logic              w_byp_b;

  assign w_wr_live = wrEn && (wrAdrs != ZERO_ADR);

  always_ff @(posedge CLK) begin
    if (reset) begin
      // NOTE: the array is small enough to reset every entry; a larger RAM-style
      // file would leave storage unreset and rely on the scoreboard instead.
      for (int i = 1; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else if (w_wr_live) begin
      r_regs[wrAdrs] <= wrData;
    end
  end

  assign w_rd_a = (rdAdrsA == ZERO_ADR) ? '0 : r_regs[rdAdrsA];
  assign w_rd_b = (rdAdrsB == ZERO_ADR) ? '0 : r_regs[rdAdrsB];

`ifdef REGFILE_BYPASS_EN
  assign w_byp_a = w_wr_live && (rdAdrsA == wrAdrs);
  assign w_byp_b = w_wr_live && (rdAdrsB == wrAdrs);
`else
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
`endif

  // A forwarded read is no longer waiting on its producer.
  assign rdDataA = w_byp_a ? wrData : w_rd_a;
  assign rdDataB = w_byp_b ? wrData : w_rd_b;
  assign rdBusyA = pendingVec[rdAdrsA] && !w_byp_a;
  assign rdBusyB = pendingVec[rdAdrsB] && !w_byp_b;

  scoreboard_bits #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .i_clk         (CLK),
    .i_reset       (reset),
    .i_issue_en    (issueEn),
    .i_issue_adrs  (issueAdrs),
    .i_wr_en       (wrEn),
    .i_wr_adrs     (wrAdrs),
    .o_issue_stall (issueStall),
    .o_pending_vec (pendingVec)
  );

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench for reg_file_scoreboard: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_reg_file_scoreboard;
  import proc_pkg::*;

  localparam data_word_t RST_VAL = 16'h0000;

  logic       CLK = 1'b0;
  logic       reset;
  reg_idx_t   rdAdrsA, rdAdrsB, issueAdrs, wrAdrs;
  data_word_t rdDataA, rdDataB, wrData;
  logic       rdBusyA, rdBusyB, issueEn, wrEn, issueStall;
  logic [NUM_REGS-1:0] pendingVec;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_scoreboard dut (
    .CLK        (CLK),
    .reset      (reset),
    .rdAdrsA    (rdAdrsA),
    .rdAdrsB    (rdAdrsB),
    .rdDataA    (rdDataA),
    .rdDataB    (rdDataB),
    .rdBusyA    (rdBusyA),
    .rdBusyB    (rdBusyB),
    .issueEn    (issueEn),
    .issueAdrs  (issueAdrs),
    .wrEn       (wrEn),
    .wrAdrs     (wrAdrs),
    .wrData     (wrData),
    .issueStall (issueStall),
    .pendingVec (pendingVec)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural register contents and the set of in-flight destinations.
  data_word_t m_regs [NUM_REGS];
  logic [NUM_REGS-1:0] m_pend;
  bit m_valid = 1'b0;

  function automatic bit forwarded(input reg_idx_t a);
`ifdef REGFILE_BYPASS_EN
    return wrEn && (wrAdrs != 0) && (wrAdrs == a);
`else
    return (a != a);
`endif
  endfunction

  function automatic data_word_t exp_data(input reg_idx_t a);
    if (a == 0) return '0;
    if (forwarded(a)) return wrData;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input reg_idx_t a);
    return (a != 0) && m_pend[a] && !forwarded(a);
  endfunction

  function automatic logic exp_stall();
    return issueEn && m_pend[issueAdrs] && !(wrEn && (wrAdrs == issueAdrs));
  endfunction

  always @(posedge CLK) begin
    bit st;
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = RST_VAL;
      m_regs[0] = '0;
      m_pend    = '0;
      m_valid   = 1'b1;
    end else if (m_valid) begin
      st = exp_stall();
      if (wrEn && wrAdrs != 0) m_regs[wrAdrs] = wrData;
      if (wrEn) m_pend[wrAdrs] = 1'b0;
      if (issueEn && issueAdrs != 0 && !st) m_pend[issueAdrs] = 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      check("cmp_rdDataA",    rdDataA,    exp_data(rdAdrsA));
      check("cmp_rdDataB",    rdDataB,    exp_data(rdAdrsB));
      check("cmp_rdBusyA",    rdBusyA,    exp_busy(rdAdrsA));
      check("cmp_rdBusyB",    rdBusyB,    exp_busy(rdAdrsB));
      check("cmp_issueStall", issueStall, exp_stall());
      check("cmp_pendingVec", pendingVec, m_pend);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    issueEn   = 1'b0;
    issueAdrs = '0;
    wrEn      = 1'b0;
    wrAdrs    = '0;
    wrData    = '0;
  endtask

  initial begin
    reset   = 1'b1;
    rdAdrsA = '0;
    rdAdrsB = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;

    for (int a = 0; a < NUM_REGS; a++) begin
      rdAdrsA = reg_idx_t'(a);
      rdAdrsB = reg_idx_t'(a);
      #1;
      check("rst_dataA", rdDataA, 16'h0000);
      check("rst_busyA", rdBusyA, 1'b0);
      check("rst_busyB", rdBusyB, 1'b0);
    end
    check("rst_pend", pendingVec, 8'h00);

    tick();
    wrEn = 1'b1; wrAdrs = 3'd0; wrData = 16'hBEEF;
    tick();
    idle(); rdAdrsA = 3'd0;
    #1;
    check("wr0_discard", rdDataA, 16'h0000);
    wrEn = 1'b1; wrAdrs = 3'd5; wrData = 16'h1234;
    tick();
    idle(); rdAdrsB = 3'd5;
    #1;
    check("wr5_readB", rdDataB, 16'h1234);

    issueEn = 1'b1; issueAdrs = 3'd3;
    tick();
    idle(); rdAdrsA = 3'd3;
    #1;
    check("issue3_pend", pendingVec, 8'h08);
    check("issue3_busyA", rdBusyA, 1'b1);
    wrEn = 1'b1; wrAdrs = 3'd3; wrData = 16'h00AA;
    tick();
    idle();
    #1;
    check("wb3_pend", pendingVec, 8'h00);
    check("wb3_dataA", rdDataA, 16'h00AA);

    issueEn = 1'b1; issueAdrs = 3'd4;
    tick();
    #1;
    check("waw_stall", issueStall, 1'b1);
    tick();
    #1;
    check("waw_pend_hold", pendingVec, 8'h10);
    wrEn = 1'b1; wrAdrs = 3'd4; wrData = 16'h7777;
    #1;
    check("waw_wb_nostall", issueStall, 1'b0);
    tick();
    idle(); rdAdrsA = 3'd4;
    #1;
    check("waw_wb_pend", pendingVec, 8'h10);
    check("waw_wb_data", rdDataA, 16'h7777);
    wrEn = 1'b1; wrAdrs = 3'd4; wrData = 16'h7777;
    tick();
    idle();

    for (int r = 2; r <= 5; r++) begin
      issueEn = 1'b1; issueAdrs = reg_idx_t'(r);
      tick();
    end
    idle();
    #1;
    check("mid_pend_3c", pendingVec, 8'h3C);
    reset = 1'b1;
    wrEn = 1'b1; wrAdrs = 3'd2; wrData = 16'hFFFF;
    issueEn = 1'b1; issueAdrs = 3'd6;
    tick();
    reset = 1'b0;
    idle(); rdAdrsA = 3'd2; rdAdrsB = 3'd5;
    #1;
    check("mid_rst_pend", pendingVec, 8'h00);
    check("mid_rst_reg2", rdDataA, RST_VAL);
    check("mid_rst_reg5", rdDataB, RST_VAL);

    wrEn = 1'b1; wrAdrs = 3'd6; wrData = 16'h5A5A; rdAdrsA = 3'd6;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_same_cycle", rdDataA, 16'h5A5A);
`else
    check("nobyp_same_cycle", rdDataA, RST_VAL);
`endif
    tick();
    idle();
    #1;
    check("byp_next_cycle", rdDataA, 16'h5A5A);

    issueEn = 1'b1; issueAdrs = 3'd0;
    #1;
    check("issue0_nostall", issueStall, 1'b0);
    tick();
    idle();
    #1;
    check("issue0_pend", pendingVec, 8'h00);

    wrEn = 1'b1; wrAdrs = 3'd7; wrData = 16'h0F0F;
    tick();
    idle(); rdAdrsA = 3'd7;
    #1;
    check("wb_nonpend_data", rdDataA, 16'h0F0F);
    check("wb_nonpend_pend", pendingVec, 8'h00);

    repeat (800) begin
      tick();
      reset     = ($urandom_range(0, 99) == 0);
      issueEn   = ($urandom_range(0, 1) == 1);
      issueAdrs = reg_idx_t'($urandom_range(0, NUM_REGS - 1));
      wrEn      = ($urandom_range(0, 2) != 0);
      wrAdrs    = reg_idx_t'($urandom_range(0, NUM_REGS - 1));
      wrData    = data_word_t'($urandom);
      rdAdrsA   = reg_idx_t'($urandom_range(0, NUM_REGS - 1));
      rdAdrsB   = reg_idx_t'($urandom_range(0, NUM_REGS - 1));
    end
    reset = 1'b0;
    idle();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
